// File: rtl/tag_engine.sv
// Two-stage keyed tag generator/checker: per-block flip+rotate under a loadable key,
// XOR-reduced to a BLOCK_SIZE tag, with valid/ready on both sides.
module tag_engine #(
    parameter int unsigned          DATA_SIZE  = 32,
    parameter int unsigned          NUM_BLOCKS = 4,
    parameter int unsigned          BLOCK_SIZE = DATA_SIZE / NUM_BLOCKS,
    parameter int unsigned          SHIFT_W    = $clog2(BLOCK_SIZE),
    parameter int unsigned          KEY_WIDTH  = NUM_BLOCKS * (1 + SHIFT_W),
    parameter logic [KEY_WIDTH-1:0] RESET_KEY  = KEY_WIDTH'(16'hDEAD),
    parameter int unsigned          CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_load,
    input  logic [KEY_WIDTH-1:0]  key_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_SIZE-1:0]  in_data,
    input  logic                  in_check,
    input  logic [BLOCK_SIZE-1:0] in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_SIZE-1:0] out_tag,
    output logic                  out_check,
    output logic                  out_mismatch,
    output logic [CNT_W-1:0]      mismatch_count
);

    // Rotate through a doubled copy so an amount of 0 never shifts by BLOCK_SIZE.
    function automatic logic [BLOCK_SIZE-1:0] rotl(input logic [BLOCK_SIZE-1:0] v,
                                                   input logic [SHIFT_W-1:0]    amt);
        logic [2*BLOCK_SIZE-1:0] dbl;
        dbl = {v, v} << amt;
        return dbl[2*BLOCK_SIZE-1 -: BLOCK_SIZE];
    endfunction

    logic [KEY_WIDTH-1:0] key_q;

    logic                                  s1_valid_q;
    logic [NUM_BLOCKS-1:0][BLOCK_SIZE-1:0] s1_blk_q, s1_blk_d;
    logic                                  s1_check_q;
    logic [BLOCK_SIZE-1:0]                 s1_tag_q;

    logic                  out_valid_q;
    logic [BLOCK_SIZE-1:0] out_tag_q, tag_d;
    logic                  out_check_q;
    logic                  out_mismatch_q, mismatch_d;
    logic [CNT_W-1:0]      cnt_q;

    logic s1_adv, s2_adv;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_blk_d = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            logic [BLOCK_SIZE-1:0] blk;
            blk = in_data[i*BLOCK_SIZE +: BLOCK_SIZE];
            if (key_q[i]) blk = ~blk;
            s1_blk_d[i] = rotl(blk, key_q[NUM_BLOCKS + i*SHIFT_W +: SHIFT_W]);
        end
    end

    always_comb begin
        tag_d = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            tag_d = tag_d ^ s1_blk_q[i];
        end
        mismatch_d = s1_check_q && (tag_d != s1_tag_q);
    end

    // Stage 1 samples key_q before this edge's key_load lands, so that word keeps the old key.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q      <= RESET_KEY;
            s1_valid_q <= 1'b0;
            s1_blk_q   <= '0;
            s1_check_q <= 1'b0;
            s1_tag_q   <= '0;
        end else begin
            if (key_load) key_q <= key_in;
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_blk_q   <= s1_blk_d;
                    s1_check_q <= in_check;
                    s1_tag_q   <= in_tag;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q    <= 1'b0;
            out_tag_q      <= '1;
            out_check_q    <= 1'b0;
            out_mismatch_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_tag_q      <= tag_d;
                    out_check_q    <= s1_check_q;
                    out_mismatch_q <= mismatch_d;
                end
            end
            if (out_valid_q && out_ready && out_mismatch_q && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_tag        = out_tag_q;
    assign out_check      = out_check_q;
    assign out_mismatch   = out_mismatch_q;
    assign mismatch_count = cnt_q;

endmodule

// File: tb/tb_tag_engine.sv
// Directed bench for tag_engine: queue-based reference model checked every cycle,
// plus hand-computed literal expectations. A CNT_W=2 twin exercises counter saturation.
module tb_tag_engine;

    logic        clk;
    logic        reset;
    logic        key_load;
    logic [15:0] key_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_check;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_tag;
    logic        out_check;
    logic        out_mismatch;
    logic [15:0] mismatch_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [7:0]  s_out_tag;
    logic        s_out_check;
    logic        s_out_mismatch;
    logic [1:0]  s_count;

    tag_engine dut (
        .clk            (clk),
        .reset          (reset),
        .key_load       (key_load),
        .key_in         (key_in),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_check       (in_check),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_tag        (out_tag),
        .out_check      (out_check),
        .out_mismatch   (out_mismatch),
        .mismatch_count (mismatch_count)
    );

    tag_engine #(.CNT_W(2)) dut_small (
        .clk            (clk),
        .reset          (reset),
        .key_load       (key_load),
        .key_in         (key_in),
        .in_valid       (in_valid),
        .in_ready       (s_in_ready),
        .in_data        (in_data),
        .in_check       (in_check),
        .in_tag         (in_tag),
        .out_valid      (s_out_valid),
        .out_ready      (out_ready),
        .out_tag        (s_out_tag),
        .out_check      (s_out_check),
        .out_mismatch   (s_out_mismatch),
        .mismatch_count (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Reference: tag computed straight from the key-layout rules with integer arithmetic.
    function automatic logic [7:0] model_tag(input logic [31:0] d, input logic [15:0] k);
        int acc;
        int b;
        int a;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            b = int'((d >> (8 * i)) & 32'hFF);
            if (k[i]) b = 255 - b;
            a = int'((k >> (4 + 3 * i)) & 16'h7);
            if (a != 0) b = ((b << a) | (b >> (8 - a))) & 255;
            acc = acc ^ b;
        end
        return 8'(acc);
    endfunction

    typedef struct packed {
        logic [7:0] tag;
        logic       chk;
        logic       mm;
    } res_t;

    res_t        q[$];
    logic [15:0] mkey = 16'hDEAD;
    int          cnt16 = 0;
    int          cnt2 = 0;
    int          delivered = 0;
    bit          stall_prev = 0;

    always @(negedge clk) begin
        res_t e;
        res_t n;
        if (!reset) begin
            q.delete();
            mkey       = 16'hDEAD;
            cnt16      = 0;
            cnt2       = 0;
            stall_prev = 0;
        end else begin
            check("in_ready", in_ready, (q.size() < 2) || out_ready);
            check("small_in_ready", s_in_ready, (q.size() < 2) || out_ready);
            check("count", mismatch_count, cnt16);
            check("small_count", s_count, cnt2);
            if (stall_prev) check("held_valid", out_valid, 1);
            check("small_valid", s_out_valid, out_valid);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("stray_output", out_valid, 0);
                end else begin
                    e = q[0];
                    check("out_tag", out_tag, e.tag);
                    check("out_check", out_check, e.chk);
                    check("out_mismatch", out_mismatch, e.mm);
                    check("small_tag", s_out_tag, e.tag);
                    check("small_check", s_out_check, e.chk);
                    check("small_mismatch", s_out_mismatch, e.mm);
                    if (out_ready) begin
                        void'(q.pop_front());
                        delivered++;
                        if (e.mm) begin
                            if (cnt16 < 65535) cnt16++;
                            if (cnt2 < 3) cnt2++;
                        end
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                n.tag = model_tag(in_data, mkey);
                n.chk = in_check;
                n.mm  = in_check && (n.tag != in_tag);
                q.push_back(n);
            end
            if (key_load) mkey = key_in;
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [31:0] d, input logic chk, input logic [7:0] t,
                        input logic kl, input logic [15:0] k);
        in_valid = 1'b1;
        in_data  = d;
        in_check = chk;
        in_tag   = t;
        key_load = kl;
        key_in   = k;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        key_load = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [7:0] t, input logic mm);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({name, "_valid"}, out_valid, 1);
        check({name, "_tag"}, out_tag, t);
        check({name, "_mm"}, out_mismatch, mm);
        @(posedge clk);
        #1;
    endtask

    logic [0:3] rdy_pat = 4'b1001;
    bit         saw_stall;
    int         base_delivered;
    int         stale;
    int         sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        reset     = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_check  = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_tag", out_tag, 8'hFF);
        check("rst_check", out_check, 0);
        check("rst_mm", out_mismatch, 0);
        check("rst_count", mismatch_count, 0);
        @(posedge clk);
        #2 reset = 1'b1;

        // Zero word: exactly two cycles of latency, all-ones tag.
        send(32'h0, 1'b0, 8'h00, 1'b0, 16'h0);
        @(negedge clk);
        check("lat_cycle1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_cycle2_valid", out_valid, 1);
        check("lat_tag", out_tag, 8'hFF);
        check("lat_mm", out_mismatch, 0);
        @(posedge clk);
        #1;

        send(32'h1, 1'b0, 8'h00, 1'b0, 16'h0);
        expect_out("gen_one", 8'hFB, 1'b0);

        send(32'h1, 1'b1, 8'hFB, 1'b0, 16'h0);
        expect_out("chk_match", 8'hFB, 1'b0);
        check("chk_count_before", mismatch_count, 0);
        send(32'h1, 1'b1, 8'hFA, 1'b0, 16'h0);
        expect_out("chk_miss", 8'hFB, 1'b1);
        check("chk_count_after", mismatch_count, 1);

        // Key loaded with the accept applies only to the following word.
        send(32'h1, 1'b0, 8'h00, 1'b1, 16'h0000);
        expect_out("key_old", 8'hFB, 1'b0);
        send(32'h1, 1'b0, 8'h00, 1'b0, 16'h0);
        expect_out("key_new", 8'h01, 1'b0);
        key_load = 1'b1;
        key_in   = 16'h5A3C;
        @(posedge clk);
        #1 key_load = 1'b0;

        // Burst of 8 with out_ready 1,0,0,1,...
        base_delivered = delivered;
        saw_stall      = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    bit acc;
                    acc      = 0;
                    in_valid = 1'b1;
                    in_data  = 32'h0F0F_1234 + i * 32'h1357_9BDF;
                    in_check = i[0];
                    in_tag   = 8'(i * 37);
                    for (int t = 0; t < 20 && !acc; t++) begin
                        @(negedge clk);
                        acc = in_ready;
                        if (!in_ready) saw_stall = 1;
                        @(posedge clk);
                        #1;
                    end
                    check("burst_accept", acc, 1);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = rdy_pat[c % 4];
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("burst_delivered", delivered - base_delivered, 8);
        check("burst_stalled", saw_stall, 1);
        check("burst_drained", q.size(), 0);

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(32'hAAAA_5555, 1'b1, 8'h00, 1'b0, 16'h0);
        send(32'h1234_5678, 1'b1, 8'h00, 1'b0, 16'h0);
        check("inflight_valid", out_valid, 1);
        check("inflight_ready", in_ready, 0);
        #1 reset = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_tag", out_tag, 8'hFF);
        check("async_count", mismatch_count, 0);
        @(posedge clk);
        @(posedge clk);
        #2 reset  = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale", stale, 0);
        @(posedge clk);
        #1;

        // Saturation of the 2-bit counter against the 16-bit one.
        for (int k = 0; k < 5; k++) begin
            send(32'h1, 1'b1, 8'h00, 1'b0, 16'h0);
            expect_out("sat_word", 8'hFB, 1'b1);
            check("sat_small", s_count, sat_exp[k]);
            check("sat_big", mismatch_count, k + 1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_drain", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
